simon_seq_store: RTL and testbench

Parametrised sequence store for the Simon game. Holds the growing colour sequence as an append-only list with a tracked length, streams it back through a valid/ready playback port for the LED/tone driver, and provides an independent registered check port for comparing player input against entry k. Sits between the random-colour generator (append side), the playback driver (stream side) and the input-compare FSM (check side).

---
 rtl/simon_defs.sv | 13 +
 rtl/seq_ram.sv | 35 +++
 rtl/simon_seq_store.sv | 117 +++++++++++
 tb/tb_simon_seq_store.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/simon_defs.sv
// Shared Simon game definitions: sequence-store state encodings and default sizes.
package simon_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_t;

  localparam int DEF_N_ELEMENTS = 64;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 4;

endpackage

// File: rtl/seq_ram.sv
// Sequence storage: reset-to-zero array, one write port, async playback read, registered check read.
module seq_ram
  import simon_defs::*;
#(
  parameter int DEPTH = DEF_N_ELEMENTS,
  parameter int AW    = DEF_ADDR_WIDTH,
  parameter int DW    = DEF_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] chk_addr,
  output logic [DW-1:0] chk_data
);

  logic [DW-1:0] mem [DEPTH];

  // Addresses past DEPTH (possible when DEPTH < 2**AW) read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      chk_data <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      chk_data <= (32'(chk_addr) < DEPTH) ? mem[chk_addr] : '0;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/simon_seq_store.sv
// Simon sequence store: append-only colour list with valid/ready playback and a registered check port.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting; appends accepted, play_start with len>0 starts
//   ST_PLAY | streaming mem[0..len-1], one entry per accepted transfer
module simon_seq_store
  import simon_defs::*;
#(
  parameter int N_ELEMENTS = DEF_N_ELEMENTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  app_en,
  input  logic [DATA_WIDTH-1:0] app_data,
  output logic [ADDR_WIDTH:0]   len,
  output logic                  full,
  input  logic                  play_start,
  output logic                  play_valid,
  input  logic                  play_ready,
  output logic [DATA_WIDTH-1:0] play_data,
  output logic                  play_last,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic [DATA_WIDTH-1:0] chk_data,
  output logic                  chk_oob
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(N_ELEMENTS);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  seq_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic                  app_ok;
  logic                  xfer;

  assign full       = (len == LEN_MAX);
  assign busy       = (state == ST_PLAY);
  assign play_valid = busy;
  assign play_last  = busy && ({1'b0, ptr} == (len - LEN_ONE));
  assign xfer       = play_valid && play_ready;
  assign app_ok     = app_en && !full && (state == ST_IDLE) && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (clr) begin
      state_nxt = ST_IDLE;
      ptr_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play_start && (len != '0)) begin
            state_nxt = ST_PLAY;
            ptr_nxt   = '0;
          end
        end
        ST_PLAY: begin
          if (xfer) begin
            if (play_last) begin
              state_nxt = ST_IDLE;
              ptr_nxt   = '0;
            end else begin
              ptr_nxt = ptr + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end
      endcase
    end
  end

  // chk_oob compares against the pre-update length, matching chk_data's old-contents read.
  always_ff @(posedge clk) begin
    if (rst) begin
      len     <= '0;
      chk_oob <= 1'b0;
    end else begin
      if (clr)         len <= '0;
      else if (app_ok) len <= len + LEN_ONE;
      chk_oob <= ({1'b0, chk_addr} >= len);
    end
  end

  seq_ram #(
    .DEPTH (N_ELEMENTS),
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (app_ok),
    .waddr    (len[ADDR_WIDTH-1:0]),
    .wdata    (app_data),
    .raddr    (ptr),
    .rdata    (play_data),
    .chk_addr (chk_addr),
    .chk_data (chk_data)
  );

endmodule

// File: tb/tb_simon_seq_store.sv
// Directed self-checking bench for simon_seq_store with hand-computed expectations.
module tb_simon_seq_store;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst, clr, app_en, play_start, play_ready;
  logic [DW-1:0] app_data;
  logic [AW:0]   len;
  logic          full, play_valid, play_last, busy, chk_oob;
  logic [DW-1:0] play_data, chk_data;
  logic [AW-1:0] chk_addr;

  int n_cmp = 0;
  int n_bad = 0;

  simon_seq_store #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .app_en     (app_en),
    .app_data   (app_data),
    .len        (len),
    .full       (full),
    .play_start (play_start),
    .play_valid (play_valid),
    .play_ready (play_ready),
    .play_data  (play_data),
    .play_last  (play_last),
    .busy       (busy),
    .chk_addr   (chk_addr),
    .chk_data   (chk_data),
    .chk_oob    (chk_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set before the call are sampled, outputs are checked 1ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_data [5] = '{4'd3, 4'd1, 4'd1, 4'd1, 4'd2};
  logic          rdy_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1; clr = 0; app_en = 0; app_data = '0; play_start = 0; play_ready = 0; chk_addr = '0;
    tick(); tick();
    check("rst_len", 32'(len), 0);
    check("rst_full", 32'(full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(play_valid), 0);
    check("rst_last", 32'(play_last), 0);
    check("rst_chk_oob", 32'(chk_oob), 0);
    check("rst_chk_data", 32'(chk_data), 0);
    rst = 0;

    // append 3,1,2
    app_en = 1; app_data = 4'd3; tick();
    check("app1_len", 32'(len), 1);
    app_data = 4'd1; tick();
    app_data = 4'd2; tick();
    app_en = 0;
    check("app3_len", 32'(len), 3);
    check("app3_full", 32'(full), 0);
    chk_addr = 6'd0; tick(); check("chk0", 32'(chk_data), 3); check("chk0_oob", 32'(chk_oob), 0);
    chk_addr = 6'd1; tick(); check("chk1", 32'(chk_data), 1);
    chk_addr = 6'd2; tick(); check("chk2", 32'(chk_data), 2); check("chk2_oob", 32'(chk_oob), 0);
    chk_addr = 6'd3; tick(); check("chk3_oob", 32'(chk_oob), 1);

    // playback with ready held high
    play_ready = 1; play_start = 1; tick(); play_start = 0;
    check("p0_valid", 32'(play_valid), 1);
    check("p0_data", 32'(play_data), 3);
    check("p0_last", 32'(play_last), 0);
    tick(); check("p1_data", 32'(play_data), 1); check("p1_last", 32'(play_last), 0);
    tick(); check("p2_data", 32'(play_data), 2); check("p2_last", 32'(play_last), 1);
    tick(); check("p_done_busy", 32'(busy), 0);

    // playback with ready pattern 1,0,0,1,1
    play_start = 1; tick(); play_start = 0;
    for (int i = 0; i < 5; i++) begin
      play_ready = rdy_pat[i];
      check("bp_valid", 32'(play_valid), 1);
      check("bp_data", 32'(play_data), 32'(exp_data[i]));
      check("bp_last", 32'(play_last), (i == 4) ? 1 : 0);
      tick();
    end
    check("bp_done_busy", 32'(busy), 0);
    play_ready = 0;

    // append during PLAY dropped, then clr aborts playback
    play_start = 1; tick(); play_start = 0;
    app_en = 1; app_data = 4'd7; tick(); app_en = 0;
    check("appbusy_len", 32'(len), 3);
    check("appbusy_busy", 32'(busy), 1);
    clr = 1; tick(); clr = 0;
    check("clrplay_busy", 32'(busy), 0);
    check("clrplay_len", 32'(len), 0);
    app_en = 1; app_data = 4'd9; tick();
    check("reapp_len", 32'(len), 1);
    clr = 1; app_data = 4'd5; tick(); clr = 0; app_en = 0;
    check("clrapp_len", 32'(len), 0);
    chk_addr = 6'd0; tick();
    check("clr_keeps_mem", 32'(chk_data), 9);
    check("clr_chk_oob", 32'(chk_oob), 1);
    play_start = 1; tick(); play_start = 0;
    check("start_empty_valid", 32'(play_valid), 0);
    tick();
    check("start_empty_busy", 32'(busy), 0);

    // fill to N_ELEMENTS, then one overflow append
    app_en = 1;
    for (int i = 0; i < N; i++) begin
      app_data = 4'((i * 5 + 1) % 16);
      tick();
      if (i == N - 2) check("fill63_full", 32'(full), 0);
    end
    check("fill_len", 32'(len), 64);
    check("fill_full", 32'(full), 1);
    app_data = 4'd3; tick(); app_en = 0;
    check("ovf_len", 32'(len), 64);
    chk_addr = 6'd63; tick();
    check("ovf_mem63", 32'(chk_data), 12);
    check("ovf_chk_oob", 32'(chk_oob), 0);

    play_ready = 1; play_start = 1; tick(); play_start = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 62) check("full_last62", 32'(play_last), 0);
      if (i == 63) begin
        check("full_last63", 32'(play_last), 1);
        check("full_data63", 32'(play_data), 12);
      end
      tick();
    end
    check("full_done_busy", 32'(busy), 0);

    // reset mid-playback
    play_start = 1; tick(); play_start = 0;
    tick(); tick();
    check("mid_busy", 32'(busy), 1);
    rst = 1; tick();
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(play_valid), 0);
    check("mrst_last", 32'(play_last), 0);
    check("mrst_len", 32'(len), 0);
    check("mrst_full", 32'(full), 0);
    check("mrst_chk", 32'(chk_data), 0);
    check("mrst_oob", 32'(chk_oob), 0);
    check("mrst_data", 32'(play_data), 0);
    rst = 0; play_ready = 0;
    for (int a = 0; a < N; a++) begin
      chk_addr = 6'(a);
      tick();
      check("mrst_mem", 32'(chk_data), 0);
    end
    check("mrst_stays_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
